// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out a 4-bit change amount with greedy coin selection over three tubes
//   (5, 2, 1).  Each coin is requested from the hopper with a req/ack handshake.
//   If the hopper does not acknowledge within ACK_TIMEOUT cycles, the block
//   reports a jam.  Per-tube inventory is tracked.  If no coin fits the
//   remaining amount, the block reports a short-pay.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, change_amt 1-cycle request to pay change_amt (accepted in IDLE only)
//   eject_ack         hopper has ejected the requested coin
//   refill            reload every tube to INV_INIT (IDLE only, start wins)
//   clear             leave FAULT
//   busy              high in every state except IDLE
//   eject_req/sel     coin request to the hopper; sel 0 = 1, 1 = 2, 2 = 5
//   done              1-cycle pulse after a complete payout
//   fault/fault_code  held in FAULT; code 01 = short-pay, 10 = jam
//   owed              amount still unpaid
//   inv_1/2/5         coins left in each tube
module change_dispenser #(
   parameter int INV_INIT    = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] change_amt,
   input  logic       eject_ack,
   input  logic       refill,
   input  logic       clear,
   output logic       busy,
   output logic       eject_req,
   output logic [1:0] eject_sel,
   output logic       done,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [3:0] owed,
   output logic [3:0] inv_1,
   output logic [3:0] inv_2,
   output logic [3:0] inv_5
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_EJECT,
      S_DONE,
      S_FAULT
   } state_t;

   localparam int              CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(ACK_TIMEOUT - 1);
   localparam logic [3:0]      INV_FULL = 4'(INV_INIT);

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [3:0]    inv_reg [3];     // index 0 = 1-tube, 1 = 2-tube, 2 = 5-tube
   logic          pick_ok;
   logic [1:0]    pick_sel;

   function automatic logic [3:0] coin_value(input logic [1:0] sel);
      case (sel)
         2'd2:    coin_value = 4'd5;
         2'd1:    coin_value = 4'd2;
         default: coin_value = 4'd1;
      endcase
   endfunction

   // Greedy pick: largest coin that fits the remainder and whose tube is not empty.
   always_comb begin
      pick_ok  = 1'b0;
      pick_sel = 2'd0;
      if (owed >= 4'd5 && inv_reg[2] != 4'd0) begin
         pick_ok  = 1'b1;
         pick_sel = 2'd2;
      end else if (owed >= 4'd2 && inv_reg[1] != 4'd0) begin
         pick_ok  = 1'b1;
         pick_sel = 2'd1;
      end else if (owed >= 4'd1 && inv_reg[0] != 4'd0) begin
         pick_ok  = 1'b1;
         pick_sel = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         busy       <= 1'b0;
         eject_req  <= 1'b0;
         eject_sel  <= 2'd0;
         done       <= 1'b0;
         fault      <= 1'b0;
         fault_code <= 2'b00;
         owed       <= 4'd0;
         cnt_reg    <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  owed      <= change_amt;
                  busy      <= 1'b1;
                  state_reg <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (owed == 4'd0) begin
                  done      <= 1'b1;
                  state_reg <= S_DONE;
               end else if (pick_ok) begin
                  eject_sel <= pick_sel;
                  eject_req <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= S_EJECT;
               end else begin
                  // Short-pay: owed keeps the unpaid remainder.
                  fault      <= 1'b1;
                  fault_code <= 2'b01;
                  state_reg  <= S_FAULT;
               end
            end
            S_EJECT: begin
               if (eject_ack) begin
                  owed      <= owed - coin_value(eject_sel);
                  eject_req <= 1'b0;
                  state_reg <= S_SELECT;
               end else if (cnt_reg == CNT_LAST) begin
                  eject_req  <= 1'b0;
                  fault      <= 1'b1;
                  fault_code <= 2'b10;
                  state_reg  <= S_FAULT;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_DONE: begin
               busy      <= 1'b0;
               state_reg <= S_IDLE;
            end
            S_FAULT: begin
               if (clear) begin
                  fault      <= 1'b0;
                  fault_code <= 2'b00;
                  owed       <= 4'd0;
                  busy       <= 1'b0;
                  state_reg  <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // One inventory counter per tube.  A tube is decremented when its coin is
   // acknowledged; refill is honoured only in IDLE without a simultaneous start.
   for (genvar gi = 0; gi < 3; gi++) begin : g_tube
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            inv_reg[gi] <= INV_FULL;
         end else if (state_reg == S_IDLE && !start && refill) begin
            inv_reg[gi] <= INV_FULL;
         end else if (state_reg == S_EJECT && eject_ack && eject_sel == 2'(gi)) begin
            inv_reg[gi] <= inv_reg[gi] - 4'd1;
         end
      end
   end

   assign inv_1 = inv_reg[0];
   assign inv_2 = inv_reg[1];
   assign inv_5 = inv_reg[2];

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
   localparam int INV_INIT    = 8;
   localparam int ACK_TIMEOUT = 16;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] change_amt;
   logic       eject_ack;
   logic       refill;
   logic       clear;
   logic       busy;
   logic       eject_req;
   logic [1:0] eject_sel;
   logic       done;
   logic       fault;
   logic [1:0] fault_code;
   logic [3:0] owed;
   logic [3:0] inv_1;
   logic [3:0] inv_2;
   logic [3:0] inv_5;

   change_dispenser #(.INV_INIT(INV_INIT), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .change_amt(change_amt),
      .eject_ack(eject_ack), .refill(refill), .clear(clear), .busy(busy),
      .eject_req(eject_req), .eject_sel(eject_sel), .done(done), .fault(fault),
      .fault_code(fault_code), .owed(owed), .inv_1(inv_1), .inv_2(inv_2), .inv_5(inv_5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit is_fault;
      int code;
      int owed;
      int i1;
      int i2;
      int i5;
   } outcome_t;

   outcome_t out_q[$];
   int       sel_q[$];
   int       checks = 0;
   int       errors = 0;
   int       m_inv[3];          // reference inventory: 0 = 1-tube, 1 = 2-tube, 2 = 5-tube
   bit       jam = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference model: greedy change-making with finite tubes.  In jam mode the
   // first coin is requested but never delivered.
   task automatic model_txn(input int amt, input bit jam_mode);
      int       vals[3] = '{1, 2, 5};
      int       rem;
      int       k;
      outcome_t o;
      rem        = amt;
      o.is_fault = 1'b0;
      o.code     = 0;
      while (rem > 0) begin
         k = -1;
         for (int i = 2; i >= 0; i--)
            if (k < 0 && vals[i] <= rem && m_inv[i] > 0) k = i;
         if (k < 0) begin
            o.is_fault = 1'b1;
            o.code     = 1;
            break;
         end
         sel_q.push_back(k);
         if (jam_mode) begin
            o.is_fault = 1'b1;
            o.code     = 2;
            break;
         end
         rem      -= vals[k];
         m_inv[k] -= 1;
      end
      o.owed = rem;
      o.i1   = m_inv[0];
      o.i2   = m_inv[1];
      o.i5   = m_inv[2];
      out_q.push_back(o);
   endtask

   // Hopper: acknowledges each request after a random delay unless jammed.
   initial begin
      int d;
      eject_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (eject_req && !jam && rst_n) begin
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            eject_ack = 1'b1;
            @(negedge clk);
            eject_ack = 1'b0;
         end
      end
   end

   // Monitor: compares each new coin request, each done pulse and each fault entry.
   initial begin
      bit       prev_req;
      bit       prev_fault;
      int       req_len;
      int       exp_sel;
      outcome_t o;
      prev_req   = 1'b0;
      prev_fault = 1'b0;
      req_len    = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_req   = 1'b0;
            prev_fault = 1'b0;
            req_len    = 0;
         end else begin
            if (eject_req && !prev_req) begin
               req_len = 0;
               if (sel_q.size() == 0) begin
                  check("unexpected_eject_req", 1, 0);
               end else begin
                  exp_sel = sel_q.pop_front();
                  check("eject_sel", int'(eject_sel), exp_sel);
               end
            end
            if (eject_req) req_len++;
            if (done) begin
               if (out_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  o = out_q.pop_front();
                  check("done_expected_fault", 0, int'(o.is_fault));
                  check("done_owed", int'(owed), 0);
                  check("done_inv_1", int'(inv_1), o.i1);
                  check("done_inv_2", int'(inv_2), o.i2);
                  check("done_inv_5", int'(inv_5), o.i5);
               end
            end
            if (fault && !prev_fault) begin
               if (out_q.size() == 0) begin
                  check("unexpected_fault", 1, 0);
               end else begin
                  o = out_q.pop_front();
                  check("fault_expected", 1, int'(o.is_fault));
                  check("fault_code", int'(fault_code), o.code);
                  check("fault_owed", int'(owed), o.owed);
                  check("fault_inv_1", int'(inv_1), o.i1);
                  check("fault_inv_2", int'(inv_2), o.i2);
                  check("fault_inv_5", int'(inv_5), o.i5);
                  if (fault_code == 2'b10) check("jam_req_cycles", req_len, ACK_TIMEOUT);
               end
            end
            prev_req   = eject_req;
            prev_fault = fault;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 1, 0);
   endtask

   task automatic do_refill();
      wait_idle();
      refill = 1'b1;
      for (int i = 0; i < 3; i++) m_inv[i] = INV_INIT;
      @(negedge clk);
      refill = 1'b0;
      check("refill_inv_1", int'(inv_1), m_inv[0]);
      check("refill_inv_2", int'(inv_2), m_inv[1]);
      check("refill_inv_5", int'(inv_5), m_inv[2]);
   endtask

   task automatic run_txn(input int amt, input bit with_refill, input bit jam_mode);
      int n;
      wait_idle();
      jam        = jam_mode;
      start      = 1'b1;
      change_amt = 4'(amt);
      refill     = with_refill;
      model_txn(amt, jam_mode);
      @(negedge clk);
      start  = 1'b0;
      refill = 1'b0;
      n      = 0;
      while (!done && !fault && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!done && !fault) check("txn_timeout", 1, 0);
      if (fault) begin
         clear = 1'b1;
         @(negedge clk);
         clear = 1'b0;
         check("clear_busy", int'(busy), 0);
         check("clear_fault", int'(fault), 0);
         check("clear_code", int'(fault_code), 0);
         check("clear_owed", int'(owed), 0);
      end
      jam = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_eject_req"}, int'(eject_req), 0);
      check({tag, "_eject_sel"}, int'(eject_sel), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_fault"}, int'(fault), 0);
      check({tag, "_fault_code"}, int'(fault_code), 0);
      check({tag, "_owed"}, int'(owed), 0);
      check({tag, "_inv_1"}, int'(inv_1), INV_INIT);
      check({tag, "_inv_2"}, int'(inv_2), INV_INIT);
      check({tag, "_inv_5"}, int'(inv_5), INV_INIT);
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      start      = 1'b0;
      change_amt = 4'd0;
      refill     = 1'b0;
      clear      = 1'b0;
      for (int i = 0; i < 3; i++) m_inv[i] = INV_INIT;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Change 8 -> coins 5, 2, 1.
      run_txn(8, 1'b0, 1'b0);

      // Change 0: done in the 2nd cycle after start, busy for 2 cycles, no request.
      wait_idle();
      start      = 1'b1;
      change_amt = 4'd0;
      model_txn(0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      check("zero_c1_busy", int'(busy), 1);
      check("zero_c1_done", int'(done), 0);
      check("zero_c1_req", int'(eject_req), 0);
      @(negedge clk);
      check("zero_c2_busy", int'(busy), 1);
      check("zero_c2_done", int'(done), 1);
      check("zero_c2_req", int'(eject_req), 0);
      @(negedge clk);
      check("zero_c3_busy", int'(busy), 0);
      check("zero_c3_done", int'(done), 0);

      // Drain the 5-tube, then change 7 -> 2, 2, 2, 1.
      do_refill();
      for (int i = 0; i < INV_INIT; i++) run_txn(5, 1'b0, 1'b0);
      run_txn(7, 1'b0, 1'b0);

      // Empty the 1- and 2-tubes, then change 3 -> short-pay.
      do_refill();
      for (int i = 0; i < INV_INIT; i++) run_txn(2, 1'b0, 1'b0);
      for (int i = 0; i < INV_INIT; i++) run_txn(1, 1'b0, 1'b0);
      run_txn(3, 1'b0, 1'b0);

      // Jam on the first coin of change 9.
      do_refill();
      run_txn(9, 1'b0, 1'b1);

      // Start and refill together: refill ignored.
      run_txn(15, 1'b0, 1'b0);
      run_txn(3, 1'b1, 1'b0);

      // Randomised traffic.
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 5) == 0) do_refill();
         run_txn(int'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0));
      end

      // Asynchronous reset in the middle of an ejection.
      do_refill();
      run_txn(3, 1'b0, 1'b0);
      wait_idle();
      jam        = 1'b1;
      start      = 1'b1;
      change_amt = 4'd15;
      model_txn(15, 1'b1);
      @(negedge clk);
      start = 1'b0;
      n     = 0;
      while (!eject_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("reset_mid_req_seen", int'(eject_req), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_values("midreset");
      sel_q.delete();
      out_q.delete();
      for (int i = 0; i < 3; i++) m_inv[i] = INV_INIT;
      jam = 1'b0;
      @(negedge clk);
      check("midreset_no_done", int'(done), 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_txn(11, 1'b0, 1'b0);
      wait_idle();

      check("sel_queue_drained", sel_q.size(), 0);
      check("out_queue_drained", out_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
